// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage between fetch and execute.
// Accepts an opcode on a valid/ready handshake, holds a one-hot control beat in
// an output register with back-pressure, flags undecodable opcodes, and issues
// MULTI_BEATS consecutive beats for opcodes marked in MULTI_MASK.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   fetch-side handshake; in_ready is combinational
//   in_opcode        opcode offered by fetch
//   out_valid/ready  execute-side handshake; out_valid registered
//   out_ctrl         one-hot control word, zero when illegal
//   out_illegal      opcode had no decode
//   out_step         beat index within the current instruction
//   out_last         final beat of the current instruction
module decode_stage #(
  parameter int unsigned             OPC_W       = 4,
  parameter int unsigned             CTRL_W      = 8,
  parameter logic [2**OPC_W-1:0]     MULTI_MASK  = 16'h0008,
  parameter int unsigned             MULTI_BEATS = 3,
  parameter int unsigned             STEP_W      = (MULTI_BEATS > 1) ? $clog2(MULTI_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [OPC_W-1:0]  in_opcode,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_illegal,
  output logic [STEP_W-1:0] out_step,
  output logic              out_last
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MULTI_BEATS - 1);

  typedef enum logic {EMPTY = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                illegal_q, illegal_d;
  logic                multi_q, multi_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                last_q, last_d;

  logic                accept;
  logic [CTRL_W-1:0]   dec_ctrl;
  logic                dec_illegal;
  logic                dec_multi;

  // Decode of the offered opcode, used only on the accepting edge.
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b1;
    if (32'(in_opcode) < CTRL_W) begin
      dec_ctrl    = CTRL_W'(1) << in_opcode;
      dec_illegal = 1'b0;
    end
    dec_multi = MULTI_MASK[in_opcode] && !dec_illegal && (MULTI_BEATS > 1);
  end

  // Room this cycle when empty or when the final beat is leaving.
  assign in_ready = (state_q == EMPTY) || (out_ready && last_q);
  assign accept   = in_valid && in_ready;

  // Next-state and holding-register update.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    multi_d   = multi_q;
    step_d    = step_q;
    last_d    = last_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = BUSY;
          ctrl_d    = dec_ctrl;
          illegal_d = dec_illegal;
          multi_d   = dec_multi;
          step_d    = '0;
          last_d    = !dec_multi;
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (!last_q) begin
            step_d = step_q + STEP_W'(1);
            last_d = ((step_q + STEP_W'(1)) == LAST_STEP);
          end else if (accept) begin
            ctrl_d    = dec_ctrl;
            illegal_d = dec_illegal;
            multi_d   = dec_multi;
            step_d    = '0;
            last_d    = !dec_multi;
          end else begin
            // Clear the fields so an idle stage presents a quiet bus.
            state_d   = EMPTY;
            ctrl_d    = '0;
            illegal_d = 1'b0;
            multi_d   = 1'b0;
            step_d    = '0;
            last_d    = 1'b0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      multi_q   <= 1'b0;
      step_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      multi_q   <= multi_d;
      step_q    <= step_d;
      last_q    <= last_d;
    end
  end

  assign out_valid   = (state_q == BUSY);
  assign out_ctrl    = ctrl_q;
  assign out_illegal = illegal_q;
  assign out_step    = step_q;
  assign out_last    = last_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus for decode_stage, checked
// against a beat-queue reference model of the expected execute-side traffic.
module tb_decode_stage;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned BEATS  = 3;
  localparam logic [15:0] MASK   = 16'h1208;  // opcode 3 legal multi; 9 and 12 undecodable

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [OPC_W-1:0]  in_opcode;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_illegal;
  logic [1:0]        out_step;
  logic              out_last;

  int checks = 0;
  int errors = 0;

  decode_stage #(
    .OPC_W(OPC_W), .CTRL_W(CTRL_W), .MULTI_MASK(MASK), .MULTI_BEATS(BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal), .out_step(out_step), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ctrl;
    logic       ill;
    int         step;
    logic       last;
  } beat_t;

  beat_t q[$];
  logic [15:0] mask_v = MASK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expand one accepted opcode into the beats execute should see.
  task automatic push_instr(input logic [3:0] op);
    int n;
    logic legal;
    legal = (int'(op) < int'(CTRL_W));
    n = (legal && mask_v[op]) ? int'(BEATS) : 1;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.ctrl = legal ? (8'd1 << op) : 8'd0;
      b.ill  = !legal;
      b.step = i;
      b.last = (i == n - 1);
      q.push_back(b);
    end
  endtask

  task automatic check_outputs(input logic ordy);
    logic exp_v;
    logic exp_rdy;
    exp_v   = (q.size() > 0);
    exp_rdy = !exp_v || (ordy && q[0].last);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_v) begin
      chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      chk("out_step", 32'(out_step), 32'(q[0].step));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic cyc(input logic iv, input logic [3:0] op, input logic ordy);
    logic hs_out;
    logic acc;
    @(negedge clk);
    in_valid  = iv;
    in_opcode = op;
    out_ready = ordy;
    #1;
    check_outputs(ordy);
    hs_out = (q.size() > 0) && ordy;
    acc    = iv && ((q.size() == 0) || (ordy && q[0].last));
    @(posedge clk);
    if (rst_n) begin
      if (hs_out) void'(q.pop_front());
      if (acc) push_instr(op);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ctrl"}, 32'(out_ctrl), 32'd0);
    chk({tag, "_illegal"}, 32'(out_illegal), 32'd0);
    chk({tag, "_step"}, 32'(out_step), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    out_ready = 1'b0;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    cyc(0, 4'd0, 1);
    cyc(0, 4'd5, 0);

    // Single-beat opcode 2.
    cyc(1, 4'd2, 1);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 1);

    // Multi-beat opcode 3; opcode 1 offered throughout, accepted on last beat.
    cyc(1, 4'd3, 1);
    cyc(1, 4'd1, 1);
    cyc(1, 4'd1, 1);
    cyc(1, 4'd1, 1);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 1);

    // Undecodable opcodes, including ones whose mask bit is set.
    cyc(1, 4'd9, 1);
    cyc(1, 4'd12, 1);
    cyc(1, 4'd15, 1);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 1);

    // Back-pressure: opcode 0 stalled 4 cycles while another opcode waits.
    cyc(1, 4'd0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 4'd5, 0);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 1);

    // Back-pressure mid multi-beat.
    cyc(1, 4'd3, 1);
    cyc(0, 4'd0, 0);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 0);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 1);

    // Back-to-back stream 0,1,2,0.
    cyc(1, 4'd0, 1);
    cyc(1, 4'd1, 1);
    cyc(1, 4'd2, 1);
    cyc(1, 4'd0, 1);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 1);

    // Random traffic and back-pressure.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 8; i++) cyc(0, 4'd0, 1);

    // Asynchronous reset in the middle of a multi-beat instruction.
    cyc(1, 4'd3, 1);
    cyc(0, 4'd0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    q.delete();
    cyc(1, 4'd2, 1);
    cyc(1, 4'd4, 1);
    #1 rst_n = 1'b1;
    cyc(0, 4'd0, 1);
    cyc(1, 4'd4, 1);
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the processor front end. It accepts an opcode from fetch over a valid/ready handshake and emits a one-hot control word to execute over a second valid/ready handshake. It adds three things beyond a plain combinational decoder: an output register with back-pressure, illegal-opcode flagging, and multi-beat sequencing for opcodes that need several execute cycles.

## Interface
- `OPC_W`, 4: opcode width in bits; must be ≥1.
- `CTRL_W`, 8: control word width. Opcode `k < CTRL_W` decodes to one-hot bit `k`.
- `MULTI_MASK`, 16'h0008: `2**OPC_W`-bit mask. If bit `k` is set, opcode `k` is multi-beat.
- `MULTI_BEATS`, 3: beats issued for a multi-beat opcode; must be ≥1.
- `STEP_W`, `max(1, $clog2(MULTI_BEATS))`: width of the step output. Derived; do not override.
- `clk` in 1: rising-edge clock; the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: an opcode is offered.
- `in_opcode` in OPC_W: the offered opcode.
- `in_ready` out 1: stage can accept this cycle. Combinational.
- `out_valid` out 1: a control beat is presented. Registered.
- `out_ready` in 1: execute consumes the beat.
- `out_ctrl` out CTRL_W: one-hot control word; all zeros when illegal. Registered.
- `out_illegal` out 1: current opcode is undecodable. Registered.
- `out_step` out STEP_W: beat index within the current instruction, starting at 0. Registered.
- `out_last` out 1: current beat is the final one for this instruction. Registered.

## Operation
Holding register fields: `ctrl`, `illegal`, `multi`, and the step counter.

States:
- **EMPTY**: `out_valid`=0.
- **BUSY**: `out_valid`=1.

Accept rule:
- Accept occurs when `in_valid && in_ready`. The opcode is decoded and the register loaded at that edge.
- If `in_opcode < CTRL_W`: `ctrl = 1 << in_opcode`, `illegal`=0.
- Otherwise: `ctrl`=0 and `illegal`=1.
- `multi = MULTI_MASK[in_opcode] && !illegal && (MULTI_BEATS > 1)`.
- Step loads 0.

Beat count and last:
- An instruction has `MULTI_BEATS` beats if `multi`, otherwise 1.
- `out_last = !multi || (step == MULTI_BEATS-1)`.

Transitions:
- EMPTY → BUSY on accept.
- BUSY, when `out_valid && out_ready && !out_last`: step increments by 1. `ctrl` and `illegal` are held.
- BUSY, when `out_valid && out_ready && out_last`:
  - With a simultaneous accept: reload from the new opcode and stay BUSY.
  - Otherwise: go to EMPTY.
- BUSY, when `out_ready`=0: every output is held stable. Outputs never change while a beat is stalled.

Ready and opcode range:
- `in_ready = !out_valid || (out_ready && out_last)`.
- `in_opcode` is ignored when `in_valid`=0. It is don't-care while `in_ready`=0.
- Every `OPC_W`-bit value is legal as input. Values with no decode raise `out_illegal` and are always single-beat, even if their `MULTI_MASK` bit is set.
- The step counter never exceeds `MULTI_BEATS-1`; it does not wrap.

## Timing
- Reset asserted (asynchronously): `out_valid`=0, `out_ctrl`=0, `out_illegal`=0, `out_step`=0, `out_last`=0, state EMPTY.
- While reset is asserted, `in_ready`=1, but no accept can occur.
- Reset mid-instruction abandons the remaining beats. No beat is issued after reset deasserts until a new accept.
- Latency: opcode accepted at edge N, first beat valid after edge N (visible in cycle N+1).
- Throughput: one single-beat instruction per cycle with `out_ready` held high. There is no bubble between back-to-back instructions.
- A multi-beat instruction occupies `MULTI_BEATS` consecutive beat handshakes. `in_ready` is low for all beats except the last (and only when `out_ready`=1 on the last).
- `in_ready` depends combinationally on `out_ready`. No combinational path exists from `in_*` to `out_*`.

## Test plan
- Reset, then idle → `out_valid`=0, `out_ctrl`=8'h00, `out_illegal`=0, `in_ready`=1. Assert `rst_n`=0 mid-stream → outputs clear immediately, without a clock edge.
- Opcode 2 accepted with `out_ready`=1 → next cycle `out_ctrl`=8'h04, `out_step`=0, `out_last`=1, `out_illegal`=0. Then `out_valid` drops.
- Opcode 3 (multi, 3 beats) with `out_ready`=1 → three beats, all `out_ctrl`=8'h08:
  - `out_step` goes 0,1,2.
  - `out_last` goes 0,0,1.
  - `in_ready` is 0 during the first two beats.
  - Opcode 1 offered on the last beat is accepted; the next beat is `out_ctrl`=8'h02.
- Opcode 9 (`CTRL_W`=8) → a single beat with `out_ctrl`=8'h00 and `out_illegal`=1. Repeat with `MULTI_MASK` bit 9 set → still a single beat.
- Back-pressure: opcode 0 accepted, `out_ready` held 0 for 4 cycles → `out_ctrl`=8'h01 stable throughout and `in_ready`=0. Release `out_ready` → beat completes.
- Stream opcodes 0,1,2,0 on consecutive cycles with `out_ready`=1 → outputs 8'h01, 8'h02, 8'h04, 8'h01 on consecutive cycles, no gaps. Drive a random `out_ready` pattern and check against a scoreboard.
